// File: rtl/sonic_cmd_sched.sv
// Shared SoNIC command executor: round-robin arbitration across per-port command
// registers, per-port control strobes, IRQ register-file writes and a response handshake.
module sonic_cmd_sched #(
  parameter int NUM_PORTS  = 2,
  parameter int RING_SIZE  = 8192,
  parameter int RESET_CYC  = 4,
  parameter int LONG_CYC   = 5000,
  parameter int NIOS_PULSE = 500,
  parameter int PW         = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                      clk_in,
  input  logic                      reset,
  input  logic [32*NUM_PORTS-1:0]   cmd_type,
  input  logic [32*NUM_PORTS-1:0]   cmd_param0,
  input  logic [32*NUM_PORTS-1:0]   cmd_param1,
  input  logic [32*NUM_PORTS-1:0]   rx_block_size,
  output logic [NUM_PORTS-1:0]      cmd_clear,
  output logic [NUM_PORTS-1:0]      soft_resetn,
  output logic [2*NUM_PORTS-1:0]    enable_sfp,
  output logic [NUM_PORTS-1:0]      set_lpbk,
  output logic [NUM_PORTS-1:0]      unset_lpbk,
  output logic [NUM_PORTS-1:0]      reset_nios,
  output logic                      irq_prg_wrena,
  output logic [7:0]                irq_prg_addr,
  output logic [31:0]               irq_prg_wrdata,
  output logic [PW-1:0]             irq_prg_port,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [PW-1:0]             resp_port,
  output logic [63:0]               resp_data,
  output logic [63:0]               resp_error,
  output logic                      busy
);

  localparam logic [31:0] CMD_NONE              = 32'd0;
  localparam logic [31:0] CMD_GET_RX_OFFSET     = 32'd1;
  localparam logic [31:0] CMD_GET_TX_OFFSET     = 32'd2;
  localparam logic [31:0] CMD_GET_RX_SIZE       = 32'd3;
  localparam logic [31:0] CMD_GET_TX_SIZE       = 32'd4;
  localparam logic [31:0] CMD_GET_RX_BLOCK_SIZE = 32'd5;
  localparam logic [31:0] CMD_SET_RX_BLOCK_SIZE = 32'd6;
  localparam logic [31:0] CMD_START_SFP1        = 32'd7;
  localparam logic [31:0] CMD_START_SFP2        = 32'd8;
  localparam logic [31:0] CMD_STOP_SFP1         = 32'd9;
  localparam logic [31:0] CMD_STOP_SFP2         = 32'd10;
  localparam logic [31:0] CMD_RESET             = 32'd11;
  localparam logic [31:0] CMD_SET_ADDR_IRQ      = 32'd12;
  localparam logic [31:0] CMD_CONFIG_IRQ        = 32'd13;
  localparam logic [31:0] CMD_LPBK_ON           = 32'd14;
  localparam logic [31:0] CMD_LPBK_OFF          = 32'd15;
  localparam logic [31:0] CMD_INIT_NETLOGIC     = 32'd16;

  localparam logic [7:0] REG_CNTL_DW0 = 8'h10;
  localparam logic [7:0] REG_CNTL_DW1 = 8'h11;
  localparam logic [7:0] REG_CNTL_DW2 = 8'h12;
  localparam logic [7:0] REG_CNTL_DW3 = 8'h13;

  typedef enum logic [1:0] {IDLE, EXECUTE, WRITEBACK, RESP} state_t;

  state_t            state;
  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     port;
  logic [31:0]       typ;
  logic [31:0]       p0;
  logic [31:0]       p1;
  logic [31:0]       cnt;
  logic [NUM_PORTS-1:0] req;
  logic              grant_valid;
  logic [PW-1:0]     grant;
  logic [PW-1:0]     next_rr;
  logic              last_cycle;
  logic [63:0]       resp_value;
  logic              known_op;

  function automatic logic [31:0] exec_len(input logic [31:0] op);
    case (op)
      CMD_RESET:                        exec_len = 32'(RESET_CYC);
      CMD_SET_ADDR_IRQ:                 exec_len = 32'd4;
      CMD_CONFIG_IRQ,
      CMD_SET_RX_BLOCK_SIZE:            exec_len = 32'd2;
      CMD_LPBK_ON, CMD_LPBK_OFF,
      CMD_INIT_NETLOGIC:                exec_len = 32'(LONG_CYC);
      default:                          exec_len = 32'd1;
    endcase
  endfunction

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++)
      req[p] = (cmd_type[32*p +: 32] != CMD_NONE);
  end

  // Scan downward so the lowest offset from rr_ptr is the one that sticks.
  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req[(int'(rr_ptr) + i) % NUM_PORTS]) begin
        grant_valid = 1'b1;
        grant       = PW'((int'(rr_ptr) + i) % NUM_PORTS);
      end
    end
    next_rr = (int'(grant) == NUM_PORTS - 1) ? '0 : grant + PW'(1);
  end

  assign last_cycle = (cnt == exec_len(typ) - 32'd1);
  assign known_op   = (typ >= CMD_GET_RX_OFFSET) && (typ <= CMD_INIT_NETLOGIC);
  assign busy       = (state != IDLE);

  always_comb begin
    case (typ)
      CMD_GET_RX_SIZE, CMD_GET_TX_SIZE: resp_value = {32'h0, 32'(RING_SIZE)};
      CMD_GET_RX_BLOCK_SIZE:            resp_value = {32'h0, rx_block_size[32*int'(port) +: 32]};
      default:                          resp_value = 64'h0;
    endcase
  end

  always_comb begin
    irq_prg_wrena  = 1'b0;
    irq_prg_addr   = 8'h0;
    irq_prg_wrdata = 32'h0;
    irq_prg_port   = '0;
    if (state == EXECUTE) begin
      case (typ)
        CMD_SET_ADDR_IRQ: begin
          irq_prg_wrena  = (cnt < 32'd4);
          irq_prg_addr   = (cnt < 32'd2) ? REG_CNTL_DW1 : REG_CNTL_DW2;
          irq_prg_wrdata = (cnt < 32'd2) ? p0 : p1;
        end
        CMD_CONFIG_IRQ: begin
          irq_prg_wrena  = (cnt < 32'd2);
          irq_prg_addr   = REG_CNTL_DW0;
          irq_prg_wrdata = p0;
        end
        CMD_SET_RX_BLOCK_SIZE: begin
          irq_prg_wrena  = (cnt < 32'd2);
          irq_prg_addr   = REG_CNTL_DW3;
          irq_prg_wrdata = p0;
        end
        default: ;
      endcase
      if (!irq_prg_wrena) begin
        irq_prg_addr   = 8'h0;
        irq_prg_wrdata = 32'h0;
      end else begin
        irq_prg_port   = port;
      end
    end
  end

  // reset_nios rises on the grant edge so the pulse covers cnt 0..NIOS_PULSE-1 exactly;
  // soft_resetn drops from the second EXECUTE cycle and is released after WRITEBACK.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      port        <= '0;
      typ         <= CMD_NONE;
      p0          <= 32'h0;
      p1          <= 32'h0;
      cnt         <= 32'h0;
      cmd_clear   <= '0;
      soft_resetn <= '1;
      enable_sfp  <= '0;
      set_lpbk    <= '0;
      unset_lpbk  <= '0;
      reset_nios  <= '0;
      resp_valid  <= 1'b0;
      resp_port   <= '0;
      resp_data   <= 64'h0;
      resp_error  <= 64'h0;
    end else begin
      cmd_clear <= '0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            state  <= EXECUTE;
            cnt    <= 32'h0;
            port   <= grant;
            typ    <= cmd_type[32*int'(grant) +: 32];
            p0     <= cmd_param0[32*int'(grant) +: 32];
            p1     <= cmd_param1[32*int'(grant) +: 32];
            rr_ptr <= next_rr;
            if (cmd_type[32*int'(grant) +: 32] == CMD_INIT_NETLOGIC)
              reset_nios[grant] <= 1'b1;
          end
        end
        EXECUTE: begin
          case (typ)
            CMD_RESET:      soft_resetn[port] <= 1'b0;
            CMD_START_SFP1: enable_sfp[2*int'(port)] <= 1'b1;
            CMD_START_SFP2: enable_sfp[2*int'(port)+1] <= 1'b1;
            CMD_STOP_SFP1:  enable_sfp[2*int'(port)] <= 1'b0;
            CMD_STOP_SFP2:  enable_sfp[2*int'(port)+1] <= 1'b0;
            CMD_LPBK_ON: begin
              set_lpbk[port]   <= 1'b1;
              unset_lpbk[port] <= 1'b0;
            end
            CMD_LPBK_OFF: begin
              set_lpbk[port]   <= 1'b0;
              unset_lpbk[port] <= 1'b1;
            end
            CMD_INIT_NETLOGIC:
              if (cnt + 32'd1 >= 32'(NIOS_PULSE)) reset_nios[port] <= 1'b0;
            default: ;
          endcase
          if (last_cycle) begin
            state           <= WRITEBACK;
            cmd_clear[port] <= 1'b1;
            resp_port       <= port;
            resp_data       <= resp_value;
            resp_error      <= known_op ? 64'd0 : 64'd1;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        WRITEBACK: begin
          if (typ == CMD_RESET) soft_resetn[port] <= 1'b1;
          state      <= RESP;
          resp_valid <= 1'b1;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sonic_cmd_sched.sv
// Bench for sonic_cmd_sched: opcode table with a response scoreboard, plus hand-written
// sequences for arbitration, IRQ writes, soft reset, backpressure and mid-command reset.
module tb_sonic_cmd_sched;

  localparam int NP = 2;
  localparam int PW = 1;
  localparam int LONG = 5000;

  localparam logic [31:0] CMD_NONE              = 32'd0;
  localparam logic [31:0] CMD_GET_TX_OFFSET     = 32'd2;
  localparam logic [31:0] CMD_GET_RX_SIZE       = 32'd3;
  localparam logic [31:0] CMD_GET_TX_SIZE       = 32'd4;
  localparam logic [31:0] CMD_GET_RX_BLOCK_SIZE = 32'd5;
  localparam logic [31:0] CMD_SET_RX_BLOCK_SIZE = 32'd6;
  localparam logic [31:0] CMD_START_SFP1        = 32'd7;
  localparam logic [31:0] CMD_START_SFP2        = 32'd8;
  localparam logic [31:0] CMD_STOP_SFP1         = 32'd9;
  localparam logic [31:0] CMD_RESET             = 32'd11;
  localparam logic [31:0] CMD_SET_ADDR_IRQ      = 32'd12;
  localparam logic [31:0] CMD_CONFIG_IRQ        = 32'd13;
  localparam logic [31:0] CMD_LPBK_ON           = 32'd14;
  localparam logic [31:0] CMD_LPBK_OFF          = 32'd15;
  localparam logic [31:0] CMD_INIT_NETLOGIC     = 32'd16;
  localparam logic [31:0] CMD_BOGUS             = 32'h0000_FFFF;

  localparam logic [7:0] DW0 = 8'h10;
  localparam logic [7:0] DW1 = 8'h11;
  localparam logic [7:0] DW2 = 8'h12;
  localparam logic [7:0] DW3 = 8'h13;

  logic               clk_in = 1'b0;
  logic               reset;
  logic [32*NP-1:0]   cmd_type, cmd_param0, cmd_param1, rx_block_size;
  logic [NP-1:0]      cmd_clear, soft_resetn, set_lpbk, unset_lpbk, reset_nios;
  logic [2*NP-1:0]    enable_sfp;
  logic               irq_prg_wrena;
  logic [7:0]         irq_prg_addr;
  logic [31:0]        irq_prg_wrdata;
  logic [PW-1:0]      irq_prg_port;
  logic               resp_valid, resp_ready;
  logic [PW-1:0]      resp_port;
  logic [63:0]        resp_data, resp_error;
  logic               busy;

  sonic_cmd_sched #(.NUM_PORTS(NP), .RING_SIZE(8192), .RESET_CYC(4), .LONG_CYC(LONG),
                    .NIOS_PULSE(500)) dut (
    .clk_in(clk_in), .reset(reset), .cmd_type(cmd_type), .cmd_param0(cmd_param0),
    .cmd_param1(cmd_param1), .rx_block_size(rx_block_size), .cmd_clear(cmd_clear),
    .soft_resetn(soft_resetn), .enable_sfp(enable_sfp), .set_lpbk(set_lpbk),
    .unset_lpbk(unset_lpbk), .reset_nios(reset_nios), .irq_prg_wrena(irq_prg_wrena),
    .irq_prg_addr(irq_prg_addr), .irq_prg_wrdata(irq_prg_wrdata),
    .irq_prg_port(irq_prg_port), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_port(resp_port), .resp_data(resp_data), .resp_error(resp_error), .busy(busy)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int          port;
    logic [63:0] data;
    logic [63:0] err;
  } resp_t;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    int          port;
  } irq_t;

  typedef struct {
    int          port;
    logic [31:0] op;
    logic [31:0] p0;
    logic [31:0] rxbs;
    logic [63:0] data;
    logic [63:0] err;
    logic [3:0]  sfp;
    logic [1:0]  setl;
    logic [1:0]  unsetl;
    int          nirq;
    logic [7:0]  addr;
  } vec_t;

  resp_t sb[$];
  irq_t  irq_log[$];
  int    clear_cnt[NP];
  int    low_cnt[NP];
  int    compared = 0;
  int    mismatched = 0;
  vec_t  tbl[14];

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Handshake is judged on values the coming posedge will see; everything else at negedge.
  task automatic step();
    if (resp_valid && resp_ready) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_resp: got port %0d data 0x%0h, expected no response",
                 resp_port, resp_data);
      end else begin
        resp_t e;
        e = sb.pop_front();
        checkOutput("resp_port", 64'(resp_port), 64'(e.port));
        checkOutput("resp_data", resp_data, e.data);
        checkOutput("resp_error", resp_error, e.err);
      end
    end
    @(negedge clk_in);
    for (int p = 0; p < NP; p++) begin
      if (cmd_clear[p]) begin
        clear_cnt[p]++;
        cmd_type[32*p +: 32] = CMD_NONE;
      end
      if (!soft_resetn[p]) low_cnt[p]++;
    end
    if (irq_prg_wrena) irq_log.push_back('{irq_prg_addr, irq_prg_wrdata, int'(irq_prg_port)});
  endtask

  task automatic applyStimulus(input int port, input logic [31:0] op, input logic [31:0] prm0,
                               input logic [31:0] prm1, input logic [63:0] edata,
                               input logic [63:0] eerr, input bit expect_resp);
    cmd_type[32*port +: 32]   = op;
    cmd_param0[32*port +: 32] = prm0;
    cmd_param1[32*port +: 32] = prm1;
    if (expect_resp) sb.push_back('{port, edata, eerr});
  endtask

  task automatic wait_done(input int limit, input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < limit) begin
      step();
      n++;
    end
    if (n >= limit) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s_timeout: got %0d pending responses after %0d cycles, expected 0",
               name, sb.size(), limit);
      sb.delete();
    end
  endtask

  initial begin
    int c0;
    int n;
    tbl[0]  = '{0, CMD_GET_RX_SIZE,       32'h0,         32'h0,    64'd8192, 64'd0, 4'b0000, 2'b00, 2'b00, 0, 8'h0};
    tbl[1]  = '{1, CMD_GET_TX_SIZE,       32'h0,         32'h0,    64'd8192, 64'd0, 4'b0000, 2'b00, 2'b00, 0, 8'h0};
    tbl[2]  = '{0, CMD_GET_RX_BLOCK_SIZE, 32'h0,         32'h1234, 64'h1234, 64'd0, 4'b0000, 2'b00, 2'b00, 0, 8'h0};
    tbl[3]  = '{1, CMD_GET_TX_OFFSET,     32'h0,         32'h0,    64'd0,    64'd0, 4'b0000, 2'b00, 2'b00, 0, 8'h0};
    tbl[4]  = '{0, CMD_START_SFP1,        32'h0,         32'h0,    64'd0,    64'd0, 4'b0001, 2'b00, 2'b00, 0, 8'h0};
    tbl[5]  = '{1, CMD_START_SFP2,        32'h0,         32'h0,    64'd0,    64'd0, 4'b1001, 2'b00, 2'b00, 0, 8'h0};
    tbl[6]  = '{0, CMD_START_SFP2,        32'h0,         32'h0,    64'd0,    64'd0, 4'b1011, 2'b00, 2'b00, 0, 8'h0};
    tbl[7]  = '{0, CMD_STOP_SFP1,         32'h0,         32'h0,    64'd0,    64'd0, 4'b1010, 2'b00, 2'b00, 0, 8'h0};
    tbl[8]  = '{1, CMD_BOGUS,             32'h0,         32'h0,    64'd0,    64'd1, 4'b1010, 2'b00, 2'b00, 0, 8'h0};
    tbl[9]  = '{0, CMD_CONFIG_IRQ,        32'hA5A5_0001, 32'h0,    64'd0,    64'd0, 4'b1010, 2'b00, 2'b00, 2, DW0};
    tbl[10] = '{1, CMD_SET_RX_BLOCK_SIZE, 32'h0000_0200, 32'h0,    64'd0,    64'd0, 4'b1010, 2'b00, 2'b00, 2, DW3};
    tbl[11] = '{1, CMD_LPBK_ON,           32'h0,         32'h0,    64'd0,    64'd0, 4'b1010, 2'b10, 2'b00, 0, 8'h0};
    tbl[12] = '{1, CMD_LPBK_OFF,          32'h0,         32'h0,    64'd0,    64'd0, 4'b1010, 2'b00, 2'b10, 0, 8'h0};
    tbl[13] = '{0, CMD_LPBK_ON,           32'h0,         32'h0,    64'd0,    64'd0, 4'b1010, 2'b01, 2'b10, 0, 8'h0};

    for (int p = 0; p < NP; p++) begin
      clear_cnt[p] = 0;
      low_cnt[p]   = 0;
    end
    reset = 1'b1;
    resp_ready = 1'b1;
    cmd_type = '0;
    cmd_param0 = '0;
    cmd_param1 = '0;
    rx_block_size = '0;
    step();
    step();
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_resp_valid", 64'(resp_valid), 64'd0);
    checkOutput("rst_soft_resetn", 64'(soft_resetn), 64'h3);
    checkOutput("rst_cmd_clear", 64'(cmd_clear), 64'd0);
    checkOutput("rst_irq_wrena", 64'(irq_prg_wrena), 64'd0);
    checkOutput("rst_enable_sfp", 64'(enable_sfp), 64'd0);
    reset = 1'b0;
    step();

    $display("[TB] arbitration: both ports request together");
    rx_block_size = {32'h800, 32'h400};
    applyStimulus(0, CMD_GET_RX_BLOCK_SIZE, 32'h0, 32'h0, 64'h400, 64'd0, 1'b1);
    applyStimulus(1, CMD_GET_RX_BLOCK_SIZE, 32'h0, 32'h0, 64'h800, 64'd0, 1'b1);
    wait_done(100, "arb");

    $display("[TB] opcode table");
    for (int i = 0; i < 14; i++) begin
      irq_log.delete();
      c0 = clear_cnt[tbl[i].port];
      rx_block_size[32*tbl[i].port +: 32] = tbl[i].rxbs;
      applyStimulus(tbl[i].port, tbl[i].op, tbl[i].p0, 32'h0, tbl[i].data, tbl[i].err, 1'b1);
      wait_done(LONG + 100, "tbl");
      checkOutput("tbl_cmd_clear_pulses", 64'(clear_cnt[tbl[i].port] - c0), 64'd1);
      checkOutput("tbl_enable_sfp", 64'(enable_sfp), 64'(tbl[i].sfp));
      checkOutput("tbl_set_lpbk", 64'(set_lpbk), 64'(tbl[i].setl));
      checkOutput("tbl_unset_lpbk", 64'(unset_lpbk), 64'(tbl[i].unsetl));
      checkOutput("tbl_irq_writes", 64'(irq_log.size()), 64'(tbl[i].nirq));
      foreach (irq_log[k]) begin
        checkOutput("tbl_irq_addr", 64'(irq_log[k].addr), 64'(tbl[i].addr));
        checkOutput("tbl_irq_data", 64'(irq_log[k].data), 64'(tbl[i].p0));
        checkOutput("tbl_irq_port", 64'(irq_log[k].port), 64'(tbl[i].port));
      end
    end

    $display("[TB] SET_ADDR_IRQ on port 1");
    irq_log.delete();
    applyStimulus(1, CMD_SET_ADDR_IRQ, 32'hDEAD_0000, 32'h1, 64'd0, 64'd0, 1'b1);
    wait_done(100, "addr_irq");
    checkOutput("addr_irq_writes", 64'(irq_log.size()), 64'd4);
    if (irq_log.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        checkOutput("addr_irq_addr", 64'(irq_log[k].addr), (k < 2) ? 64'(DW1) : 64'(DW2));
        checkOutput("addr_irq_data", 64'(irq_log[k].data), (k < 2) ? 64'hDEAD_0000 : 64'h1);
        checkOutput("addr_irq_port", 64'(irq_log[k].port), 64'd1);
      end
    end

    $display("[TB] RESET on port 0");
    low_cnt[0] = 0;
    low_cnt[1] = 0;
    applyStimulus(0, CMD_RESET, 32'h0, 32'h0, 64'd0, 64'd0, 1'b1);
    wait_done(100, "reset_cmd");
    checkOutput("soft_resetn0_low_cycles", 64'(low_cnt[0]), 64'd4);
    checkOutput("soft_resetn1_low_cycles", 64'(low_cnt[1]), 64'd0);
    checkOutput("soft_resetn_after", 64'(soft_resetn), 64'h3);

    $display("[TB] backpressure with unknown opcode");
    resp_ready = 1'b0;
    applyStimulus(0, CMD_BOGUS, 32'h0, 32'h0, 64'd0, 64'd1, 1'b1);
    n = 0;
    while (!resp_valid && n < 20) begin
      step();
      n++;
    end
    checkOutput("bp_resp_valid_seen", 64'(resp_valid), 64'd1);
    for (int k = 0; k < 10; k++) begin
      step();
      checkOutput("bp_hold_valid", 64'(resp_valid), 64'd1);
      checkOutput("bp_hold_port", 64'(resp_port), 64'd0);
      checkOutput("bp_hold_data", resp_data, 64'd0);
      checkOutput("bp_hold_error", resp_error, 64'd1);
    end
    resp_ready = 1'b1;
    wait_done(100, "bp");

    $display("[TB] reset during INIT_NETLOGIC");
    c0 = clear_cnt[0];
    applyStimulus(0, CMD_INIT_NETLOGIC, 32'h0, 32'h0, 64'd0, 64'd0, 1'b0);
    n = 0;
    while (!busy && n < 10) begin
      step();
      n++;
    end
    for (int k = 0; k < 100; k++) step();
    checkOutput("init_reset_nios_cnt100", 64'(reset_nios), 64'h1);
    checkOutput("init_busy_cnt100", 64'(busy), 64'd1);
    #1 reset = 1'b1;
    #1;
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_reset_nios", 64'(reset_nios), 64'd0);
    checkOutput("abort_soft_resetn", 64'(soft_resetn), 64'h3);
    checkOutput("abort_enable_sfp", 64'(enable_sfp), 64'd0);
    checkOutput("abort_set_lpbk", 64'(set_lpbk), 64'd0);
    checkOutput("abort_unset_lpbk", 64'(unset_lpbk), 64'd0);
    checkOutput("abort_cmd_clear", 64'(cmd_clear), 64'd0);
    checkOutput("abort_resp_valid", 64'(resp_valid), 64'd0);
    checkOutput("abort_resp_data", resp_data, 64'd0);
    checkOutput("abort_irq_wrena", 64'(irq_prg_wrena), 64'd0);
    cmd_type = '0;
    step();
    step();
    reset = 1'b0;
    for (int k = 0; k < 20; k++) step();
    checkOutput("abort_no_cmd_clear", 64'(clear_cnt[0] - c0), 64'd0);
    checkOutput("abort_idle_after", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
